seven_seg_scanner: RTL and testbench

Downstream display stage for the four-digit BCD counter controller. Consumes the 16-bit packed digit word and the 4-bit per-digit blink flags and drives a common-anode, time-multiplexed 4-digit seven-segment display. Digit values are frame-coherent, flagged digits blink at a slow visible rate, and a one-cycle frame tick is provided for downstream use.

---
 rtl/seven_seg_scanner.sv | 157 +++++++++++++++
 tb/tb_seven_seg_scanner.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode 4-digit seven-segment scanner with frame-coherent digit capture,
// per-digit blink and a frame tick. Optional leading-zero blanking: SEG_LEADING_ZERO_BLANK_EN.
module seven_seg_scanner #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] Qdata,
  input  logic [3:0]  blink,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        frame_tick
);

  localparam int unsigned PcW = $clog2(SCAN_DIV);
  localparam int unsigned FcW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PcW-1:0] PcLast = PcW'(SCAN_DIV - 1);
  localparam logic [FcW-1:0] FcLast = FcW'(BLINK_FRAMES - 1);

  logic [PcW-1:0] pc_q, pc_d;
  logic [1:0]     idx_q, idx_d;
  logic [FcW-1:0] fc_q, fc_d;
  logic           phase_q, phase_d;
  logic [15:0]    shadow_data_q, shadow_data_d;
  logic [3:0]     shadow_blink_q, shadow_blink_d;
  logic [3:0]     an_n_q, an_n_d;
  logic [6:0]     seg_n_q, seg_n_d;
  logic           frame_tick_q, frame_tick_d;

  logic        load;
  logic        pc_wrap;
  logic        frame_end;
  logic [15:0] cur_data;
  logic [3:0]  cur_blink;
  logic [3:0]  nibble;
  logic        blink_blank;
  logic        zero_blank;
  logic        blank;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // Scan position and blink phase
  always_comb begin
    load      = (pc_q == '0) && (idx_q == 2'd0);
    pc_wrap   = (pc_q == PcLast);
    frame_end = pc_wrap && (idx_q == 2'd3);

    pc_d  = pc_wrap ? '0 : pc_q + 1'b1;
    idx_d = pc_wrap ? idx_q + 2'd1 : idx_q;

    fc_d    = fc_q;
    phase_d = phase_q;
    if (frame_end) begin
      if (fc_q == FcLast) begin
        fc_d    = '0;
        phase_d = ~phase_q;
      end else begin
        fc_d = fc_q + 1'b1;
      end
    end
  end

  // Live inputs are used in the load cycle so digit0 appears without an extra cycle of latency.
  always_comb begin
    shadow_data_d  = load ? Qdata : shadow_data_q;
    shadow_blink_d = load ? blink : shadow_blink_q;
    cur_data       = load ? Qdata : shadow_data_q;
    cur_blink      = load ? blink : shadow_blink_q;

    nibble      = cur_data[3:0];
    blink_blank = 1'b0;
    zero_blank  = 1'b0;
    unique case (idx_q)
      2'd0: begin
        nibble      = cur_data[3:0];
        blink_blank = cur_blink[0];
      end
      2'd1: begin
        nibble      = cur_data[7:4];
        blink_blank = cur_blink[1];
`ifdef SEG_LEADING_ZERO_BLANK_EN
        zero_blank  = (cur_data[15:4] == 12'h000);
`endif
      end
      2'd2: begin
        nibble      = cur_data[11:8];
        blink_blank = cur_blink[2];
`ifdef SEG_LEADING_ZERO_BLANK_EN
        zero_blank  = (cur_data[15:8] == 8'h00);
`endif
      end
      2'd3: begin
        nibble      = cur_data[15:12];
        blink_blank = cur_blink[3];
`ifdef SEG_LEADING_ZERO_BLANK_EN
        zero_blank  = (cur_data[15:12] == 4'h0);
`endif
      end
      default: begin
        nibble      = cur_data[3:0];
        blink_blank = 1'b0;
      end
    endcase

    blank = (blink_blank && phase_q) || zero_blank;

    an_n_d       = blank ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_n_d      = blank ? 7'h7F : decode(nibble);
    frame_tick_d = frame_end;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q           <= '0;
      idx_q          <= 2'd0;
      fc_q           <= '0;
      phase_q        <= 1'b0;
      shadow_data_q  <= 16'h0000;
      shadow_blink_q <= 4'h0;
      an_n_q         <= 4'b1111;
      seg_n_q        <= 7'h7F;
      frame_tick_q   <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      idx_q          <= idx_d;
      fc_q           <= fc_d;
      phase_q        <= phase_d;
      shadow_data_q  <= shadow_data_d;
      shadow_blink_q <= shadow_blink_d;
      an_n_q         <= an_n_d;
      seg_n_q        <= seg_n_d;
      frame_tick_q   <= frame_tick_d;
    end
  end

  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: directed and random stimulus against a cycle-count based model
// of the scan, capture, blink and frame-tick rules.
module tb_seven_seg_scanner;

  localparam int unsigned S     = 4;
  localparam int unsigned BF    = 2;
  localparam int unsigned FRAME = 4 * S;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] qdata = 16'h0000;
  logic [3:0]  blink = 4'h0;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        frame_tick;

  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned t = 0;
  logic [15:0] fr_data = 16'h0000;
  logic [3:0]  fr_blink = 4'h0;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_tick;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .SCAN_DIV    (S),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Qdata     (qdata),
    .blink     (blink),
    .an_n      (an_n),
    .seg_n     (seg_n),
    .frame_tick(frame_tick)
  );

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return (v < 4'd10) ? tbl[v] : 7'h3F;
  endfunction

  // t counts cycles since reset release; everything follows from its position in the frame.
  task automatic model();
    int unsigned pos, d, f;
    logic [3:0]  nib;
    logic        blank;
    if (reset) begin
      exp_an   = 4'b1111;
      exp_seg  = 7'h7F;
      exp_tick = 1'b0;
      t        = 0;
    end else begin
      pos = t % FRAME;
      f   = t / FRAME;
      if (pos == 0) begin
        fr_data  = qdata;
        fr_blink = blink;
      end
      d     = pos / S;
      nib   = 4'(fr_data >> (4 * d));
      blank = fr_blink[d] && (((f / BF) % 2) == 1);
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (d > 0 && (fr_data >> (4 * d)) == 16'h0000) blank = 1'b1;
`endif
      exp_tick = (pos == FRAME - 1);
      exp_an   = blank ? 4'b1111 : 4'(~(4'b0001 << d));
      exp_seg  = blank ? 7'h7F : seg_of(nib);
      t++;
    end
  endtask

  task automatic step(input string tag);
    model();
    @(posedge clk);
    #1;
    n_cmp++;
    assert (an_n === exp_an) else begin
      n_err++;
      $error("FAIL %s an_n t=%0d observed=%b expected=%b", tag, t, an_n, exp_an);
    end
    n_cmp++;
    assert (seg_n === exp_seg) else begin
      n_err++;
      $error("FAIL %s seg_n t=%0d observed=%h expected=%h", tag, t, seg_n, exp_seg);
    end
    n_cmp++;
    assert (frame_tick === exp_tick) else begin
      n_err++;
      $error("FAIL %s frame_tick t=%0d observed=%b expected=%b", tag, t, frame_tick, exp_tick);
    end
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    reset = 1'b1;
    qdata = 16'($urandom);
    blink = 4'($urandom);
    run(3, "reset");

    reset = 1'b0;
    qdata = 16'h9675;
    blink = 4'h0;
    run(2 * FRAME, "scan");

    run(S + 1, "coherence_pre");
    qdata = 16'h1234;
    run(2 * FRAME - S - 1, "coherence");

    qdata = 16'h9675;
    blink = 4'b0001;
    run(5 * FRAME, "blink");

    blink = 4'h0;
    qdata = 16'hFA08;
    run(2 * FRAME, "decode_edge");

    qdata = 16'h0075;
    run(2 * FRAME, "lead_zero");
    qdata = 16'h0000;
    run(2 * FRAME, "all_zero");

    qdata = 16'h4321;
    run(5, "pre_midreset");
    reset = 1'b1;
    run(2, "midreset");
    reset = 1'b0;
    run(2 * FRAME, "post_midreset");

    for (int i = 0; i < 400; i++) begin
      qdata = 16'($urandom);
      blink = 4'($urandom);
      reset = ($urandom_range(0, 79) == 0);
      step("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
